// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: control FSM for an add-shift multiplier datapath.
// Sequences clear/load, WIDTH add-then-shift iterations and an optional
// final subtract (two's-complement correction of the multiplier sign bit).
// Configuration macro: MULT_SEQ_CTRL_AUTOCLR_EN
//   defined   -> every run starts with a one-cycle CLR state (A/X cleared).
//   undefined -> IDLE goes straight to ADD; A/X keep their previous contents,
//                so consecutive runs multiply the previous result.
// Handshake: Run is a level request. The FSM leaves IDLE when Run is seen
// high, ignores Run until HOLD, and returns to IDLE only after Run is seen
// low in HOLD, so a held Run never retriggers.
module mult_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       Clr_Ld,
  output logic       Clr_A,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic       Done,
  output logic [2:0] dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  // Final iteration of the add/shift loop.
  assign last        = (cnt_q == LAST_CNT);
  assign dbg_state_o = state_q;

  // State and iteration counter registers, asynchronous reset to IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (Run) begin
`ifdef MULT_SEQ_CTRL_AUTOCLR_EN
          state_d = ST_CLR;
`else
          state_d = ST_ADD;
`endif
        end
      end
      ST_CLR:   state_d = ST_ADD;
      ST_ADD:   state_d = ST_SHIFT;
      ST_SHIFT: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? ST_HOLD : ST_ADD;
      end
      ST_HOLD: begin
        if (!Run) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; Clr_Ld/Add/Sub also depend on inputs, the rest on state only.
  always_comb begin
    Clr_Ld = 1'b0;
    Clr_A  = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Done   = 1'b0;
    case (state_q)
      // Reset gates Clr_Ld so nothing toggles while Reset is held.
      ST_IDLE:  Clr_Ld = ClearA_LoadB & ~Run & ~Reset;
`ifdef MULT_SEQ_CTRL_AUTOCLR_EN
      ST_CLR:   Clr_A  = 1'b1;
`endif
      ST_ADD: begin
        Add = M & ~(last & SIGNED);
        Sub = M & last & SIGNED;
      end
      ST_SHIFT: Shift = 1'b1;
      ST_HOLD:  Done  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl: a signed (SIGNED=1) and an unsigned (SIGNED=0)
// instance share all inputs. A timeline model expands each run into its
// per-cycle expected output vector {Clr_Ld,Clr_A,Add,Sub,Shift,Done}.
module tb_mult_seq_ctrl;

  localparam int W = 8;
`ifdef MULT_SEQ_CTRL_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  logic Clk, Reset, Run, ClearA_LoadB, M;
  logic s_clr_ld, s_clr_a, s_add, s_sub, s_shift, s_done;
  logic u_clr_ld, u_clr_a, u_add, u_sub, u_shift, u_done;
  logic [2:0] s_dbg, u_dbg;

  int compared = 0;
  int mismatched = 0;

  logic [5:0] exp_s_q[$];
  logic [5:0] exp_u_q[$];
  logic       run_q[$];
  logic       m_q[$];
  logic       cl_q[$];

  mult_seq_ctrl #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(s_clr_ld), .Clr_A(s_clr_a), .Add(s_add), .Sub(s_sub),
    .Shift(s_shift), .Done(s_done), .dbg_state_o(s_dbg)
  );

  mult_seq_ctrl #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(u_clr_ld), .Clr_A(u_clr_a), .Add(u_add), .Sub(u_sub),
    .Shift(u_shift), .Done(u_done), .dbg_state_o(u_dbg)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [5:0] es, input logic [5:0] eu);
    check({tag, "_s"}, {s_clr_ld, s_clr_a, s_add, s_sub, s_shift, s_done}, es);
    check({tag, "_u"}, {u_clr_ld, u_clr_a, u_add, u_sub, u_shift, u_done}, eu);
  endtask

  task automatic push(input logic r, input logic mm, input logic c,
                      input logic [5:0] es, input logic [5:0] eu);
    run_q.push_back(r);
    m_q.push_back(mm);
    cl_q.push_back(c);
    exp_s_q.push_back(es);
    exp_u_q.push_back(eu);
  endtask

  // Expand one multiply (multiplier bits mb, LSB first) into a cycle timeline.
  task automatic build_run(input logic [W-1:0] mb, input int hold, input logic first_cl);
    logic c, lst, as, ss, au;
    push(1'b1, rnd(), first_cl, 6'b0, 6'b0);
    if (AUTOCLR) push(rnd(), rnd(), rnd(), 6'b010000, 6'b010000);
    for (int k = 0; k < W; k++) begin
      lst = (k == W - 1);
      as  = mb[k] & ~lst;
      ss  = mb[k] & lst;
      au  = mb[k];
      push(rnd(), mb[k], rnd(), {2'b00, as, ss, 2'b00}, {2'b00, au, 1'b0, 2'b00});
      push(rnd(), rnd(), rnd(), 6'b000010, 6'b000010);
    end
    for (int h = 0; h < hold; h++) push(1'b1, rnd(), rnd(), 6'b000001, 6'b000001);
    push(1'b0, rnd(), rnd(), 6'b000001, 6'b000001);
    c = rnd();
    push(1'b0, rnd(), c, {c, 5'b0}, {c, 5'b0});
  endtask

  // Drive and check up to n queued cycles.
  task automatic play(input int n);
    logic [5:0] es, eu;
    for (int i = 0; i < n && run_q.size() > 0; i++) begin
      Run          = run_q.pop_front();
      M            = m_q.pop_front();
      ClearA_LoadB = cl_q.pop_front();
      es           = exp_s_q.pop_front();
      eu           = exp_u_q.pop_front();
      #2;
      check_both("cycle", es, eu);
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic flush();
    run_q.delete();
    m_q.delete();
    cl_q.delete();
    exp_s_q.delete();
    exp_u_q.delete();
  endtask

  initial begin
    // Reset state
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b1; M = 1'b1;
    #2;
    check_both("reset_hold", 6'b0, 6'b0);
    @(posedge Clk); #1;
    Reset = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
    #2;
    check_both("after_reset", 6'b0, 6'b0);
    @(posedge Clk); #1;

    // IDLE load: Clr_Ld follows ClearA_LoadB while Run is low
    push(1'b0, rnd(), 1'b1, 6'b100000, 6'b100000);
    push(1'b0, rnd(), 1'b1, 6'b100000, 6'b100000);
    push(1'b0, rnd(), 1'b0, 6'b0, 6'b0);
    play(3);

    // Run has priority over ClearA_LoadB; single Add in iteration 0
    build_run(8'h01, 0, 1'b1);
    play(run_q.size());

    // All ones: Sub only in the last iteration for the signed instance;
    // Run held in HOLD, then released and immediately restarted
    build_run(8'hFF, 5, 1'b0);
    build_run(8'h80, 2, 1'b0);
    play(run_q.size());

    // Randomised multipliers
    for (int r = 0; r < 6; r++) begin
      build_run(W'($urandom), $urandom_range(0, 3), rnd());
      play(run_q.size());
    end

    // Reset asserted mid-SHIFT of the first iteration
    build_run(8'hA5, 0, 1'b0);
    play(AUTOCLR ? 3 : 2);
    flush();
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b1;
    #2;
    check_both("reset_mid_shift", 6'b0, 6'b0);
    @(posedge Clk); #1;
    check_both("reset_held", 6'b0, 6'b0);
    Reset = 1'b0; ClearA_LoadB = 1'b0;
    push(1'b0, rnd(), 1'b0, 6'b0, 6'b0);
    push(1'b0, rnd(), 1'b0, 6'b0, 6'b0);
    play(2);

    // A normal run works after the mid-run reset
    build_run(8'h5A, 1, 1'b0);
    play(run_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
